// File: rtl/i2s_dac_tx_if.sv
// Sample-pair handshake between the synth voice mixer and the I2S DAC serializer.
// The mixer drives one stereo pair with s_valid; the serializer answers with s_ready.
interface i2s_dac_tx_if #(
    parameter int DATA_WIDTH = 24
);
    logic [DATA_WIDTH-1:0] s_left;
    logic [DATA_WIDTH-1:0] s_right;
    logic                  s_valid;
    logic                  s_ready;

    modport master (output s_left, output s_right, output s_valid, input s_ready);
    modport slave  (input s_left, input s_right, input s_valid, output s_ready);
endinterface

// File: rtl/i2s_dac_tx.sv
// Philips I2S transmitter: one-slot holding register, BCK/LRCK generation and MSB-first serializer.
// Optional underrun counter is enabled by defining I2S_DAC_UNDERRUN_CNT_EN.
module i2s_dac_tx #(
    parameter int DATA_WIDTH = 24,
    parameter int SLOT_BITS  = 32,
    parameter int BCK_DIV    = 3
) (
    input  logic       AUDIO_CLK,
    input  logic       iRST_N,
    i2s_dac_tx_if.slave s_if,
    input  logic       mute,
    output logic       sample_req,
    output logic       underrun,
    output logic       AUD_BCK,
    output logic       AUD_LRCK,
    output logic       AUD_DATA
`ifdef I2S_DAC_UNDERRUN_CNT_EN
    ,
    output logic [15:0] underrun_cnt,
    input  logic        underrun_clr
`endif
);

    localparam int PW   = $clog2(2 * SLOT_BITS);
    localparam int DIVW = (BCK_DIV > 1) ? $clog2(BCK_DIV) : 1;

    localparam logic [DIVW-1:0] DIV_LAST = DIVW'(BCK_DIV - 1);
    localparam logic [PW-1:0]   P_LAST   = PW'(2 * SLOT_BITS - 1);
    localparam logic [PW-1:0]   P_ONE    = PW'(1);
    localparam logic [PW-1:0]   P_SLOT   = PW'(SLOT_BITS);
    localparam logic [PW-1:0]   P_LEND   = PW'(DATA_WIDTH);
    localparam logic [PW-1:0]   P_RBEG   = PW'(SLOT_BITS + 1);
    localparam logic [PW-1:0]   P_REND   = PW'(SLOT_BITS + DATA_WIDTH);

    logic [DIVW-1:0]       r_div;
    logic                  r_bck;
    logic [PW-1:0]         r_p;
    logic                  r_lrck;
    logic                  r_data;
    logic                  r_ready;
    logic                  r_sampleReq;
    logic                  r_underrun;
    logic [DATA_WIDTH-1:0] r_holdL;
    logic [DATA_WIDTH-1:0] r_holdR;
    logic [DATA_WIDTH-1:0] r_shL;
    logic [DATA_WIDTH-1:0] r_shR;

    logic                  w_fall;
    logic                  w_load;
    logic                  w_xfer;
    logic [PW-1:0]         w_pNext;
    logic [DATA_WIDTH-1:0] w_loadL;
    logic [DATA_WIDTH-1:0] w_loadR;

    // The load and the handshake both look at the holding state from before this edge,
    // so a pair arriving in the load cycle is kept for the following frame.
    assign w_fall  = r_bck && (r_div == DIV_LAST);
    assign w_load  = w_fall && (r_p == P_LAST);
    assign w_xfer  = s_if.s_valid && r_ready;
    assign w_pNext = (r_p == P_LAST) ? '0 : r_p + P_ONE;
    assign w_loadL = (!r_ready && !mute) ? r_holdL : '0;
    assign w_loadR = (!r_ready && !mute) ? r_holdR : '0;

    always_ff @(posedge AUDIO_CLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_div <= '0;
            r_bck <= 1'b0;
        end else if (r_div == DIV_LAST) begin
            r_div <= '0;
            r_bck <= ~r_bck;
        end else begin
            r_div <= r_div + DIVW'(1);
        end
    end

    // Serializer: the MSB of each shift register goes out on the position after the LRCK edge.
    always_ff @(posedge AUDIO_CLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_p    <= '0;
            r_lrck <= 1'b0;
            r_data <= 1'b0;
            r_shL  <= '0;
            r_shR  <= '0;
        end else if (w_fall) begin
            r_p    <= w_pNext;
            r_lrck <= (w_pNext >= P_SLOT);
            r_data <= 1'b0;
            if (w_load) begin
                r_shL <= w_loadL;
                r_shR <= w_loadR;
            end else if ((w_pNext >= P_ONE) && (w_pNext <= P_LEND)) begin
                r_data <= r_shL[DATA_WIDTH-1];
                r_shL  <= r_shL << 1;
            end else if ((w_pNext >= P_RBEG) && (w_pNext <= P_REND)) begin
                r_data <= r_shR[DATA_WIDTH-1];
                r_shR  <= r_shR << 1;
            end
        end
    end

    always_ff @(posedge AUDIO_CLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_holdL     <= '0;
            r_holdR     <= '0;
            r_ready     <= 1'b1;
            r_sampleReq <= 1'b0;
            r_underrun  <= 1'b0;
        end else begin
            r_sampleReq <= w_load;
            r_underrun  <= w_load && r_ready;
            if (w_xfer) begin
                r_holdL <= s_if.s_left;
                r_holdR <= s_if.s_right;
                r_ready <= 1'b0;
            end else if (w_load && !r_ready) begin
                r_ready <= 1'b1;
            end
        end
    end

    assign s_if.s_ready = r_ready;
    assign sample_req   = r_sampleReq;
    assign underrun     = r_underrun;
    assign AUD_BCK      = r_bck;
    assign AUD_LRCK     = r_lrck;
    assign AUD_DATA     = r_data;

`ifdef I2S_DAC_UNDERRUN_CNT_EN
    logic [15:0] r_underrunCnt;

    // Clear takes priority over a coincident underrun pulse.
    always_ff @(posedge AUDIO_CLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_underrunCnt <= '0;
        end else if (underrun_clr) begin
            r_underrunCnt <= '0;
        end else if (r_underrun && (r_underrunCnt != 16'hFFFF)) begin
            r_underrunCnt <= r_underrunCnt + 16'd1;
        end
    end

    assign underrun_cnt = r_underrunCnt;
`endif

endmodule

// File: tb/tb_i2s_dac_tx.sv
// Bench for i2s_dac_tx: closed-form timing/frame model driven by directed and $urandom stimulus.
// The model derives BCK, slot position and frame number from the cycle count since reset release.
module tb_i2s_dac_tx;

   localparam int DW    = 24;
   localparam int SB    = 32;
   localparam int DIV   = 3;
   localparam int BPER  = 2 * DIV;
   localparam int FRAME = BPER * 2 * SB;

   logic clk = 1'b0;
   logic rstN = 1'b0;
   logic mute;
   logic sampleReq, underrun, bck, lrck, data;
`ifdef I2S_DAC_UNDERRUN_CNT_EN
   logic [15:0] underrunCnt;
   logic underrunClr;
`endif

   i2s_dac_tx_if #(.DATA_WIDTH(DW)) sIf ();

   i2s_dac_tx #(.DATA_WIDTH(DW), .SLOT_BITS(SB), .BCK_DIV(DIV)) dut (
      .AUDIO_CLK(clk),
      .iRST_N(rstN),
      .s_if(sIf),
      .mute(mute),
      .sample_req(sampleReq),
      .underrun(underrun),
      .AUD_BCK(bck),
      .AUD_LRCK(lrck),
      .AUD_DATA(data)
`ifdef I2S_DAC_UNDERRUN_CNT_EN
      ,
      .underrun_cnt(underrunCnt),
      .underrun_clr(underrunClr)
`endif
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   // Reference model state: n counts rising edges since reset release
   int n;
   bit mFull;
   logic [DW-1:0] mHoldL, mHoldR, mCurL, mCurR;
   bit mReq, mUnd;
   int mCnt;

   task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s actual=%0h expected=%0h n=%0d t=%0t", tag, act, exp, n, $time);
      end
   endtask

   function automatic int expData();
      int p;
      p = (n / BPER) % (2 * SB);
      if (p >= 1 && p <= DW) return int'(mCurL[DW - p]);
      if (p >= SB + 1 && p <= SB + DW) return int'(mCurR[DW - (p - SB)]);
      return 0;
   endfunction

   task automatic checkAll();
      int p;
      p = (n / BPER) % (2 * SB);
      checkOutput("bck", 32'(bck), 32'((n / DIV) % 2));
      checkOutput("lrck", 32'(lrck), (p >= SB) ? 32'd1 : 32'd0);
      checkOutput("data", 32'(data), 32'(expData()));
      checkOutput("s_ready", 32'(sIf.s_ready), mFull ? 32'd0 : 32'd1);
      checkOutput("sample_req", 32'(sampleReq), 32'(mReq));
      checkOutput("underrun", 32'(underrun), 32'(mUnd));
`ifdef I2S_DAC_UNDERRUN_CNT_EN
      checkOutput("underrun_cnt", 32'(underrunCnt), 32'(mCnt));
`endif
   endtask

   task automatic modelReset();
      n = 0;
      mFull = 1'b0;
      mHoldL = '0;
      mHoldR = '0;
      mCurL = '0;
      mCurR = '0;
      mReq = 1'b0;
      mUnd = 1'b0;
      mCnt = 0;
   endtask

   task automatic checkResetState(input string tag);
      checkOutput({tag, "_bck"}, 32'(bck), 32'd0);
      checkOutput({tag, "_lrck"}, 32'(lrck), 32'd0);
      checkOutput({tag, "_data"}, 32'(data), 32'd0);
      checkOutput({tag, "_ready"}, 32'(sIf.s_ready), 32'd1);
      checkOutput({tag, "_req"}, 32'(sampleReq), 32'd0);
      checkOutput({tag, "_und"}, 32'(underrun), 32'd0);
`ifdef I2S_DAC_UNDERRUN_CNT_EN
      checkOutput({tag, "_cnt"}, 32'(underrunCnt), 32'd0);
`endif
   endtask

   // Drives one cycle of inputs, advances the model over the coming edge, then checks
   task automatic applyStimulus(input bit v, input logic [DW-1:0] l, input logic [DW-1:0] r,
                                input bit m, input bit clr);
      bit xfer, load;
      sIf.s_valid = v;
      sIf.s_left = l;
      sIf.s_right = r;
      mute = m;
`ifdef I2S_DAC_UNDERRUN_CNT_EN
      underrunClr = clr;
      if (clr) mCnt = 0;
      else if (mUnd && mCnt < 65535) mCnt++;
`endif
      xfer = v && !mFull;
      load = ((n + 1) % FRAME) == 0;
      if (load) begin
         mReq = 1'b1;
         if (mFull) begin
            mCurL = m ? '0 : mHoldL;
            mCurR = m ? '0 : mHoldR;
            mUnd = 1'b0;
            mFull = 1'b0;
         end else begin
            mCurL = '0;
            mCurR = '0;
            mUnd = 1'b1;
         end
      end else begin
         mReq = 1'b0;
         mUnd = 1'b0;
      end
      if (xfer) begin
         mHoldL = l;
         mHoldR = r;
         mFull = 1'b1;
      end
      n++;
      @(posedge clk);
      @(negedge clk);
      checkAll();
   endtask

   task automatic idle(input int cycles, input bit m);
      for (int i = 0; i < cycles; i++) applyStimulus(1'b0, '0, '0, m, 1'b0);
   endtask

   task automatic releaseReset();
      @(negedge clk);
      checkResetState("rst");
      rstN = 1'b1;
      modelReset();
      checkAll();
   endtask

   initial begin
      logic [DW-1:0] inc, rl, rr;
      sIf.s_valid = 1'b0;
      sIf.s_left = '0;
      sIf.s_right = '0;
      mute = 1'b0;
`ifdef I2S_DAC_UNDERRUN_CNT_EN
      underrunClr = 1'b0;
`endif
      modelReset();
      repeat (3) @(negedge clk);
      releaseReset();

      $display("[TB] idle after reset");
      idle(2 * FRAME + 10, 1'b0);

      $display("[TB] single pair 800001/7FFFFF");
      applyStimulus(1'b1, 24'h800001, 24'h7FFFFF, 1'b0, 1'b0);
      idle(2 * FRAME, 1'b0);

      $display("[TB] continuous valid with incrementing data");
      inc = 24'h000100;
      for (int i = 0; i < 3 * FRAME; i++) begin
         applyStimulus(1'b1, inc, ~inc, 1'b0, 1'b0);
         inc = inc + 24'd1;
      end

      $display("[TB] valid in the load cycle with empty holding");
      idle(FRAME, 1'b0);
      for (int i = 0; i < FRAME; i++) begin
         if (((n + 1) % FRAME) == 0) break;
         applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
      end
      applyStimulus(1'b1, 24'hA5C3E1, 24'h1E3C5A, 1'b0, 1'b0);
      idle(2 * FRAME, 1'b0);

      $display("[TB] mute at load");
      applyStimulus(1'b1, 24'h123456, 24'h654321, 1'b1, 1'b0);
      idle(FRAME, 1'b1);
      applyStimulus(1'b1, 24'h0F0F0F, 24'hF0F0F0, 1'b0, 1'b0);
      idle(2 * FRAME, 1'b0);

      $display("[TB] random stimulus");
      for (int i = 0; i < 6 * FRAME; i++) begin
         rl = DW'($urandom);
         rr = DW'($urandom);
         applyStimulus(($urandom % 150) == 0, rl, rr, ($urandom % 4) == 0,
                       ($urandom % 700) == 0);
      end

      $display("[TB] reset in the right slot");
      for (int i = 0; i < 2 * FRAME; i++) begin
         if ((n % FRAME) == 40 * BPER + 2) break;
         applyStimulus(1'b1, 24'hABCDEF, 24'h123123, 1'b0, 1'b0);
      end
      checkOutput("pre_rst_lrck", 32'(lrck), 32'd1);
      sIf.s_valid = 1'b0;
      #2 rstN = 1'b0;
      #1 checkResetState("async");
      releaseReset();
      idle(2 * FRAME, 1'b0);

`ifdef I2S_DAC_UNDERRUN_CNT_EN
      $display("[TB] underrun counter");
      @(negedge clk);
      rstN = 1'b0;
      releaseReset();
      idle(3 * FRAME + 1, 1'b0);
      checkOutput("cnt_three", 32'(underrunCnt), 32'd3);
      idle(FRAME - 1, 1'b0);
      checkOutput("und_pulse", 32'(underrun), 32'd1);
      applyStimulus(1'b0, '0, '0, 1'b0, 1'b1);
      checkOutput("cnt_clr", 32'(underrunCnt), 32'd0);
      idle(10, 1'b0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
